fetch_ifid: RTL and testbench

FETCH_IFID -- requirements
Module: fetch_ifid

---
 rtl/fetch_ifid.sv | 75 +++++++
 tb/tb_fetch_ifid.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifid.sv
// Instruction fetch stage and IF/ID pipeline register for a 32-bit MIPS-style core.
// Redirect flushes IF/ID, stall freezes it, and a memory wait state inserts bubbles.
module fetch_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_WORD = RESET_PC & WORD_MASK;

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4  = pc + XLEN'(PC_STEP);
    assign imem_addr = pc;

    // Decoder-facing field split of the registered instruction.
    assign opcode = ifid_instr[31:26];
    assign rs     = ifid_instr[25:21];
    assign rt     = ifid_instr[20:16];
    assign rd     = ifid_instr[15:11];
    assign shamt  = ifid_instr[10:6];
    assign func   = ifid_instr[5:0];

    // Priority: reset, redirect, stall, memory wait, normal fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC_WORD;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            pc         <= branch_target & WORD_MASK;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (stall) begin
            pc         <= pc;
            ifid_instr <= ifid_instr;
            ifid_pc4   <= ifid_pc4;
            ifid_valid <= ifid_valid;
        end else if (!imem_ready) begin
            // Same address is retried next cycle; decode sees a NOP meanwhile.
            pc         <= pc;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_plus4;
            ifid_instr <= imem_rdata;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed vector table, hand sequences,
// and randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_ifid;

    localparam logic [31:0] RESET_PC_P = 32'h0000_0003;
    localparam logic [31:0] RESET_EXP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, imem_ready;
    logic [31:0] branch_target, imem_rdata, imem_addr, pc, ifid_instr, ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd, shamt;

    always #5 clk = ~clk;

    fetch_ifid #(.RESET_PC(RESET_PC_P)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func)
    );

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_chk  = 0;

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t, logic rdy,
                                logic [31:0] d, logic [31:0] ep, logic [31:0] ei,
                                logic [31:0] e4, logic ev);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ready = rdy; v.rdata = d;
        v.e_pc = ep; v.e_instr = ei; v.e_pc4 = e4; v.e_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic rdy, input logic [31:0] d);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        imem_ready = rdy; imem_rdata = d;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic check_state(input string tag, input logic [31:0] ep, input logic [31:0] ei,
                               input logic [31:0] e4, input logic ev);
        chk({tag, ".pc"}, pc, ep);
        chk({tag, ".imem_addr"}, imem_addr, ep);
        chk({tag, ".instr"}, ifid_instr, ei);
        chk({tag, ".pc4"}, ifid_pc4, e4);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(ev));
        chk({tag, ".opcode"}, 32'(opcode), 32'(ei >> 26));
        chk({tag, ".rs"}, 32'(rs), (ei >> 21) & 32'h1F);
        chk({tag, ".rt"}, 32'(rt), (ei >> 16) & 32'h1F);
        chk({tag, ".rd"}, 32'(rd), (ei >> 11) & 32'h1F);
        chk({tag, ".shamt"}, 32'(shamt), (ei >> 6) & 32'h1F);
        chk({tag, ".func"}, 32'(func), ei & 32'h3F);
    endtask

    // Behavioural reference: architectural state updated by the fetch rules.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic rdy, input logic [31:0] d);
        if (r) begin
            m_pc = RESET_PC_P - (RESET_PC_P % 4);
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (b) begin
            m_pc = t - (t % 4);
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (s) begin
            // nothing changes
        end else if (!rdy) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            m_pc = m_pc + 4;
            m_instr = d; m_pc4 = m_pc; m_valid = 1;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_ready = 1'b0; imem_rdata = '0;

        //           rst s  br tgt           rdy rdata          e_pc          e_instr        e_pc4         v
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, RESET_EXP,    32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0022_1820, 32'h4,        32'h0022_1820, 32'h4,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAAAA_0001, 32'h8,        32'hAAAA_0001, 32'h8,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h1234_5678, 32'h8,        32'hAAAA_0001, 32'h8,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8765_4321, 32'h8,        32'hAAAA_0001, 32'h8,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'hFFFF_FFFF, 32'h8,        32'hAAAA_0001, 32'h8,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1111_0002, 32'hC,        32'h1111_0002, 32'hC,        1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2222_0003, 32'h10,       32'h2222_0003, 32'h10,       1));
        vecs.push_back(mk(0, 1, 1, 32'h103,      1, 32'h9999_9999, 32'h100,      32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 32'h14,       0, 32'h9999_9999, 32'h14,       32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h7777_7777, 32'h14,       32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h7777_7777, 32'h14,       32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h3333_0005, 32'h18,       32'h3333_0005, 32'h18,       1));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFF,1, 32'h9999_9999, 32'hFFFF_FFFC, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4444_0006, 32'h0,        32'h4444_0006, 32'h0,        1));
        vecs.push_back(mk(0, 0, 1, 32'h28,       1, 32'h9999_9999, 32'h28,       32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h5555_0007, 32'h2C,       32'h5555_0007, 32'h2C,       1));
        vecs.push_back(mk(0, 0, 1, 32'h28,       1, 32'h9999_9999, 32'h28,       32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h9999_9999, 32'h28,       32'h0,         32'h0,        0));
        vecs.push_back(mk(1, 1, 1, 32'h500,      0, 32'h9999_9999, RESET_EXP,    32'h0,         32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h6666_0008, 32'h4,        32'h6666_0008, 32'h4,        1));

        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt,
                       vecs[i].ready, vecs[i].rdata);
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                        vecs[i].e_pc4, vecs[i].e_valid);
            if (i == 1) begin
                chk("add.opcode", 32'(opcode), 32'd0);
                chk("add.rs", 32'(rs), 32'd1);
                chk("add.rt", 32'(rt), 32'd2);
                chk("add.rd", 32'(rd), 32'd3);
                chk("add.func", 32'(func), 32'h20);
            end
        end

        // Redirect held for three cycles reloads a fresh target each cycle.
        drive_edge(0, 0, 1, 32'h0000_0200, 1, 32'hABCD_0000);
        check_state("hold_br0", 32'h200, 32'h0, 32'h0, 0);
        drive_edge(0, 1, 1, 32'h0000_0301, 1, 32'hABCD_0001);
        check_state("hold_br1", 32'h300, 32'h0, 32'h0, 0);
        drive_edge(0, 0, 1, 32'h0000_0402, 0, 32'hABCD_0002);
        check_state("hold_br2", 32'h400, 32'h0, 32'h0, 0);
        drive_edge(0, 0, 0, 32'h0, 1, 32'hABCD_0003);
        check_state("hold_rel", 32'h404, 32'hABCD_0003, 32'h404, 1);

        // Reset during a memory wait state.
        drive_edge(0, 0, 0, 32'h0, 0, 32'h0);
        check_state("wait", 32'h404, 32'h0, 32'h0, 0);
        drive_edge(1, 0, 0, 32'h0, 0, 32'h0);
        check_state("wait_rst", RESET_EXP, 32'h0, 32'h0, 0);

        // Randomized traffic against the model.
        model_step(1, 0, 0, 0, 0, 0);
        drive_edge(1, 0, 0, 32'h0, 0, 32'h0);
        check_state("rnd_init", m_pc, m_instr, m_pc4, m_valid);
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, b, rdy;
            logic [31:0] t, d;
            r   = ($urandom % 64) == 0;
            b   = ($urandom % 8) == 0;
            s   = ($urandom % 4) == 0;
            rdy = ($urandom % 4) != 0;
            t   = $urandom;
            if (($urandom % 6) == 0) t = 32'hFFFF_FFF0 | ($urandom % 16);
            d   = $urandom;
            model_step(r, s, b, t, rdy, d);
            drive_edge(r, s, b, t, rdy, d);
            check_state($sformatf("rnd%0d", i), m_pc, m_instr, m_pc4, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
